// File: rtl/byte_serial_add32.sv
// 8-bit ripple-carry adder slice, shared by the byte-serial sequencer below.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs.
module rca8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// 32-bit add/subtract computed one byte per clock through a single rca8.
// Latency: 5 cycles from accepted start to the done pulse; one operation per 6 cycles.
// Backpressure: start is ignored unless idle; result holds until the next accepted start.
module byte_serial_add32 #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                overflow,
    output logic                busy,
    output logic                done
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry;
    logic [IW-1:0] idx;

    logic [7:0] slice_a;
    logic [7:0] slice_b;
    logic [7:0] rca_sum;
    logic       rca_cout;

    assign slice_a = op_a[8*idx +: 8];
    assign slice_b = op_b[8*idx +: 8];

    rca8 u_rca8 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as a + ~b + 1; a set borrow-in cancels the +1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[8*idx +: 8] <= rca_sum;
                    carry           <= rca_cout;
                    idx             <= idx + IW'(1);
                    if (idx == LAST) begin
                        cout     <= rca_cout;
                        overflow <= (op_a[W-1] == op_b[W-1]) && (rca_sum[7] != op_a[W-1]);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_add32.sv
// Directed and random bench for byte_serial_add32 with a result scoreboard.
module tb_byte_serial_add32;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        busy;
    logic        done;

    int   checks   = 0;
    int   failures = 0;
    res_t sb[$];

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    byte_serial_add32 #(.NBYTES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic s);
        res_t       r;
        logic [32:0] u;
        longint     sx, sy, sr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            u   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            sr  = sx + sy + longint'(ci);
            r.c = u[32];
        end else begin
            u   = {1'b0, x} - {1'b0, y} - {32'd0, ci};
            sr  = sx - sy - longint'(ci);
            r.c = ~u[32];
        end
        r.s = u[31:0];
        r.v = (sr > MAXS) || (sr < MINS);
        return r;
    endfunction

    task automatic compare_pop(input string tag);
        res_t r;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            r = sb.pop_front();
            chk({tag, "_sum"}, sum, r.s);
            chk({tag, "_cout"}, {31'd0, cout}, {31'd0, r.c});
            chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, r.v});
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input res_t e);
        int lat;
        lat = 0;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            if (done) lat = k;
        end
        chk({tag, "_latency"}, lat, 32'd5);
        if (lat != 0) begin
            chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
            compare_pop(tag);
        end else begin
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   ndone;
        res_t e;
        logic [31:0] ra, rb;
        logic        rc, rs;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sum", sum, 32'd0);
        chk("rst_flags", {28'd0, cout, overflow, busy, done}, 32'd0);
        rst = 1'b0;

        run_op("byte_carry", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0});
        run_op("full_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0});
        run_op("sovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1});
        run_op("sovf_cin", 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, '{32'h80000001, 1'b0, 1'b1});
        run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0});
        run_op("sub_borrow", 32'd7, 32'd5, 1'b1, 1'b1, '{32'h00000001, 1'b1, 1'b0});
        run_op("sub_minint", 32'h00000000, 32'h80000000, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b1});

        // start held high with operands churning through RUN and DONE
        @(negedge clk);
        a = 32'h12345678; b = 32'h9ABCDEF0; cin = 1'b1; sub = 1'b0; start = 1'b1;
        sb.push_back(model(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0));
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("hold_latency", k, 32'd5);
                compare_pop("hold");
            end
            if (k < 6) begin
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk("hold_ndone", ndone, 32'd1);

        // reset sampled at E2 of an operation
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_flags", {28'd0, cout, overflow, busy, done}, 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_nodone", ndone, 32'd0);
        run_op("after_rst", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00010000, 1'b0, 1'b0});

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            e  = model(ra, rb, rc, rs);
            run_op("rand", ra, rb, rc, rs, e);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
